// File: rtl/md_ctrl_pkg.sv
// Shared HI/LO unit definitions: operation encodings, default latencies, FSM states.
package md_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit multiply / 32-bit divide on the latched operands.
// Purely combinational; the controller decides when the result is committed.
module md_arith
    import md_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] b_nz;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    // Divisor is forced non-zero so the dividers never see 0; the commit is suppressed anyway.
    assign b_nz     = (b == 32'd0) ? 32'd1 : b;
    assign div_zero = (b == 32'd0);

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign quot_s = $signed(a) / $signed(b_nz);
    assign rem_s  = $signed(a) % $signed(b_nz);
    assign quot_u = a / b_nz;
    assign rem_u  = a % b_nz;

    always_comb begin
        hi_res = 32'd0;
        lo_res = 32'd0;
        case (op)
            MD_MULT:  {hi_res, lo_res} = prod_s;
            MD_MULTU: {hi_res, lo_res} = prod_u;
            MD_DIV:   begin hi_res = rem_s; lo_res = quot_s; end
            MD_DIVU:  begin hi_res = rem_u; lo_res = quot_u; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO multiply-divide controller: latches operands, counts MULT/DIV latency, commits HI/LO.
// Result visible the cycle busy falls; md_stall holds a dependent D-stage instruction meanwhile.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(DIV_CYCLES) + 1;

    md_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;

    logic [31:0] hi_res;
    logic [31:0] lo_res;
    logic        div_zero;

    md_arith u_arith (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .hi_res   (hi_res),
        .lo_res   (lo_res),
        .div_zero (div_zero)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            state_d = ST_RUN;
                            op_d    = md_op;
                            a_d     = rs_val;
                            b_d     = rt_val;
                            cnt_d   = is_div_op(md_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        end
                        MD_MTHI: hi_d = rs_val;
                        MD_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    // A zero-divisor divide still takes its full latency but leaves HI/LO intact.
                    if (!(is_div_op(op_q) && div_zero)) begin
                        hi_d = hi_res;
                        lo_d = lo_res;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    // busy term is masked while reset is asserted so an aborted op cannot stall the pipe.
    assign md_stall = d_is_md & ((busy_q & reset) | (start & is_long_op(md_op)));
    assign busy     = busy_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl with a cycle-level reference model and literal result checks.
module tb_md_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    md_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .d_is_md  (d_is_md),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: remaining busy cycles plus a pending result applied when they run out.
    int          m_left = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;
    logic [31:0] p_hi = 0;
    logic [31:0] p_lo = 0;
    bit          p_vld = 0;
    longint      sa, sb, q, r;
    logic [63:0] pr;

    always @(posedge clk) begin
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_left = 0; p_vld = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_vld) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (start) begin
            sa = longint'($signed(rs_val));
            sb = longint'($signed(rt_val));
            case (md_op)
                3'd1, 3'd2: begin
                    if (md_op == 3'd2) begin
                        sa = longint'({32'd0, rs_val});
                        sb = longint'({32'd0, rt_val});
                    end
                    pr = 64'(sa * sb);
                    p_hi = pr[63:32]; p_lo = pr[31:0]; p_vld = 1;
                    m_left = MC;
                end
                3'd3, 3'd4: begin
                    if (md_op == 3'd4) begin
                        sa = longint'({32'd0, rs_val});
                        sb = longint'({32'd0, rt_val});
                    end
                    p_vld = (rt_val != 0);
                    if (p_vld) begin
                        q = sa / sb;
                        r = sa - q * sb;
                        p_lo = q[31:0]; p_hi = r[31:0];
                    end
                    m_left = DC;
                end
                3'd5: m_hi = rs_val;
                3'd6: m_lo = rs_val;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", {31'd0, busy}, {31'd0, m_left > 0});
            chk("cyc_stall", {31'd0, md_stall},
                {31'd0, d_is_md && ((m_left > 0 && reset) ||
                                    (start && md_op >= 3'd1 && md_op <= 3'd4))});
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        md_op = op; rs_val = a; rt_val = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        if (n >= 100) chk("timeout_busy", 32'd1, 32'd0);
    endtask

    int n;

    initial begin
        reset = 1'b0; start = 1'b0; md_op = 3'd0; rs_val = 0; rt_val = 0; d_is_md = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_en = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b1;

        d_is_md = 1'b1;
        run_op(3'd1, 32'hFFFFFFFD, 32'd5, n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);
        chk("stall_at_fall", {31'd0, md_stall}, 32'd0);

        run_op(3'd2, 32'hFFFFFFFD, 32'd5, n);
        chk("multu_cycles", n, 32'd5);
        chk("multu_hi", hi, 32'h00000004);
        chk("multu_lo", lo, 32'hFFFFFFF1);

        d_is_md = 1'b0;
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, n);
        chk("div_cycles", n, 32'd10);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        run_op(3'd4, 32'd7, 32'd2, n);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        run_op(3'd5, 32'h11, 32'd0, n);
        run_op(3'd6, 32'h22, 32'd0, n);
        run_op(3'd3, 32'd99, 32'd0, n);
        chk("div0_cycles", n, 32'd10);
        chk("div0_hi", hi, 32'h11);
        chk("div0_lo", lo, 32'h22);

        d_is_md = 1'b1;
        run_op(3'd5, 32'h1234, 32'd0, n);
        chk("mthi_busy", n, 32'd0);
        chk("mthi_hi", hi, 32'h1234);

        run_op(3'd0, 32'hDEAD, 32'hBEEF, n);
        run_op(3'd7, 32'hDEAD, 32'hBEEF, n);
        chk("ign_hi", hi, 32'h1234);
        chk("ign_lo", lo, 32'h22);
        chk("ign_busy", n, 32'd0);

        // start held high during busy must not disturb the running multiply
        md_op = 3'd2; rs_val = 32'd2; rt_val = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        md_op = 3'd4; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        n = 0;
        while (busy && n < 100) begin n++; @(posedge clk); #1; end
        chk("busy_start_lo", lo, 32'd6);
        chk("busy_start_hi", hi, 32'd0);

        // reset asserted during the 3rd busy cycle of a divide
        md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #2;
        chk("stall_in_rst", {31'd0, md_stall}, 32'd0);
        @(posedge clk); #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        reset = 1'b1;

        run_op(3'd1, 32'd7, 32'd6, n);
        chk("post_rst_cycles", n, 32'd5);
        chk("post_rst_lo", lo, 32'd42);
        chk("post_rst_hi", hi, 32'd0);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
